add_pipe_mc: RTL and testbench

ADD_PIPE_MC -- requirements
Module: add_pipe_mc

---
 rtl/add_pipe_mc.sv | 181 ++++++++++++++++++
 tb/tb_add_pipe_mc.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_mc.sv
// add_pipe_mc: multi-channel adder/accumulator with a fixed-latency, stallable result pipeline.
//
// Each accepted request is evaluated in its accept cycle. ADD, ACC, CLR and LOAD all produce a
// result there, and ACC, CLR and LOAD also update the per-channel accumulator in that cycle.
// The result then passes through PIPE_STAGES registered stages. The last stage drives the
// output port.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready
//   in_op      2'b00 ADD, 2'b01 ACC, 2'b10 CLR, 2'b11 LOAD
//   in_ch      target channel (CH_W bits)
//   in_a/in_b  unsigned operands (DATA_WIDTH bits each); in_b is used by ADD only
//   out_valid  result valid
//   out_ready  sink ready; result transferred when out_valid & out_ready
//   out_ch     channel of the result
//   out_sum    result (ACC_W = DATA_WIDTH + ACC_EXT bits)
//   out_ovf    carry out of the accumulator on ACC
//
// Build option
//   ADD_PIPE_MC_SAT_EN  When defined, ACC saturates at 2^ACC_W-1 and the channel stays
//                       saturated until the next CLR or LOAD. When undefined, ACC wraps.

module add_pipe_mc #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_EXT     = 4,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned PIPE_STAGES = 2,
  localparam int unsigned ACC_W      = DATA_WIDTH + ACC_EXT,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_ovf
);

  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpAcc  = 2'b01,
    OpClr  = 2'b10,
    OpLoad = 2'b11
  } op_e;

`ifdef ADD_PIPE_MC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  localparam int unsigned SumW = ACC_W + 1;
  // With NUM_CH == 1 the single channel bit is forced to zero so it always addresses acc[0].
  localparam logic [CH_W-1:0] ChMask = CH_W'(NUM_CH - 1);

  // Per-channel accumulator state.
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W-1:0] acc_d [NUM_CH];
  // Sticky saturation flag. It only ever becomes set in the saturating build.
  logic             sat_q [NUM_CH];
  logic             sat_d [NUM_CH];

  // Result pipeline. Index 0 is loaded at accept. Index PIPE_STAGES-1 drives the outputs.
  logic             stg_vld_q [PIPE_STAGES];
  logic [CH_W-1:0]  stg_ch_q  [PIPE_STAGES];
  logic [ACC_W-1:0] stg_sum_q [PIPE_STAGES];
  logic             stg_ovf_q [PIPE_STAGES];

  op_e              op;
  logic [CH_W-1:0]  ch_sel;
  logic             stall;
  logic             accept;
  logic [ACC_W-1:0] add_sum;
  logic [SumW-1:0]  acc_full;
  logic [ACC_W-1:0] res_sum;
  logic             res_ovf;

  assign op     = op_e'(in_op);
  assign ch_sel = in_ch & ChMask;

  // Handshake. While reset is asserted, out_valid and in_ready are both forced low.
  // This guarantees that no transfer of either kind happens in a reset cycle.
  assign out_valid = stg_vld_q[PIPE_STAGES-1] & ~rst;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall & ~rst;
  assign accept    = in_valid & in_ready;

  assign out_ch  = stg_ch_q[PIPE_STAGES-1];
  assign out_sum = stg_sum_q[PIPE_STAGES-1];
  assign out_ovf = stg_ovf_q[PIPE_STAGES-1];

  // ADD result is zero-extended into the accumulator width.
  assign add_sum  = ACC_W'(in_a) + ACC_W'(in_b);
  // ACC is computed one bit wider so the carry out of ACC_W is visible.
  assign acc_full = {1'b0, acc_q[ch_sel]} + SumW'(in_a);

  // Evaluate the request and compute the next accumulator state.
  // The accumulator is written in the accept cycle. A following request to the same channel
  // therefore reads the updated value with no forwarding logic.
  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    res_sum = '0;
    res_ovf = 1'b0;

    case (op)
      OpAdd: begin
        res_sum = add_sum;
      end
      OpAcc: begin
        if (SatEn && (acc_full[ACC_W] || sat_q[ch_sel])) begin
          res_sum = '1;
          res_ovf = 1'b1;
        end else begin
          res_sum = acc_full[ACC_W-1:0];
          res_ovf = acc_full[ACC_W];
        end
      end
      OpClr: begin
        res_sum = '0;
      end
      OpLoad: begin
        res_sum = ACC_W'(in_a);
      end
      default: begin
        res_sum = '0;
      end
    endcase

    // ADD leaves the accumulator untouched. CLR and LOAD always clear saturation.
    if (accept && (op != OpAdd)) begin
      acc_d[ch_sel] = res_sum;
      sat_d[ch_sel] = SatEn && (op == OpAcc) && res_ovf;
    end
  end

  // Pipeline and accumulator registers.
  // During a stall nothing moves, so no accept can happen and every stage holds.
  // Outside a stall the whole pipeline shifts, and bubbles shift along with valid results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end
      for (int i = 0; i < PIPE_STAGES; i++) begin
        stg_vld_q[i] <= 1'b0;
        stg_ch_q[i]  <= '0;
        stg_sum_q[i] <= '0;
        stg_ovf_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      acc_q <= acc_d;
      sat_q <= sat_d;

      // Bubbles carry zeroed data, which keeps the idle outputs deterministic.
      stg_vld_q[0] <= accept;
      stg_ch_q[0]  <= accept ? ch_sel  : '0;
      stg_sum_q[0] <= accept ? res_sum : '0;
      stg_ovf_q[0] <= accept & res_ovf;

      for (int i = 1; i < PIPE_STAGES; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_ch_q[i]  <= stg_ch_q[i-1];
        stg_sum_q[i] <= stg_sum_q[i-1];
        stg_ovf_q[i] <= stg_ovf_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_add_pipe_mc.sv
// Self-checking bench for add_pipe_mc at the default parameters (8/4/2/2).

module tb_add_pipe_mc;

  localparam int unsigned DW     = 8;
  localparam int unsigned AE     = 4;
  localparam int unsigned NCH    = 2;
  localparam int unsigned PS     = 2;
  localparam int unsigned AW     = DW + AE;
  localparam int unsigned CHW    = 1;
  localparam int unsigned AccMax = (1 << AW) - 1;

`ifdef ADD_PIPE_MC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_op;
  logic [CHW-1:0] in_ch;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [AW-1:0]  out_sum;
  logic           out_ovf;

  add_pipe_mc #(
    .DATA_WIDTH (DW),
    .ACC_EXT    (AE),
    .NUM_CH     (NCH),
    .PIPE_STAGES(PS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_ch    (in_ch),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           vld;
    logic [CHW-1:0] ch;
    logic [AW-1:0]  sum;
    logic           ovf;
  } res_t;

  res_t        got_q [$];
  res_t        exp_q [$];
  res_t        pend_q[$];
  int          got_cyc[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned m_acc [NCH];
  bit          m_sat [NCH];

  // Reference model: one call per accepted request, in acceptance order.
  function automatic res_t model(input logic [1:0] op, input int unsigned ch,
                                 input int unsigned a, input int unsigned b);
    res_t        r;
    int unsigned full;
    r.vld = 1'b1;
    r.ch  = CHW'(ch);
    r.ovf = 1'b0;
    r.sum = '0;
    case (op)
      2'd0: r.sum = AW'(a + b);
      2'd1: begin
        full = m_acc[ch] + a;
        if (SatEn && (full > AccMax || m_sat[ch])) begin
          m_acc[ch] = AccMax;
          m_sat[ch] = 1'b1;
          r.ovf     = 1'b1;
        end else if (full > AccMax) begin
          m_acc[ch] = full - (AccMax + 1);
          r.ovf     = 1'b1;
        end else begin
          m_acc[ch] = full;
        end
        r.sum = AW'(m_acc[ch]);
      end
      2'd2: begin
        m_acc[ch] = 0;
        m_sat[ch] = 1'b0;
      end
      default: begin
        m_acc[ch] = a;
        m_sat[ch] = 1'b0;
        r.sum     = AW'(a);
      end
    endcase
    return r;
  endfunction

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [CHW-1:0] ch,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = v;
    in_op    = op;
    in_ch    = ch;
    in_a     = a;
    in_b     = b;
  endtask

  // One clock cycle. Handshakes are observed at the negedge. The model is fed on each accept.
  // Every delivered result is paired with the oldest outstanding expectation.
  // The task returns 1 ns after the next posedge.
  task automatic cycle();
    res_t g;
    @(negedge clk);
    if (rst) begin
      pend_q.delete();
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0;
        m_sat[i] = 1'b0;
      end
    end else begin
      if (out_valid && out_ready) begin
        g = {1'b1, out_ch, out_sum, out_ovf};
        got_q.push_back(g);
        got_cyc.push_back(cyc);
        if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        else exp_q.push_back('0);
      end
      if (in_valid && in_ready) pend_q.push_back(model(in_op, in_ch, in_a, in_b));
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    clear_logs();
    rst       = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 2'd0, 1'b0, 8'h01, 8'h01);
    repeat (3) cycle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_sum !== '0) $display("FAIL reset_out_sum: got %h want 0", out_sum); else n_pass++;
    n_checks++; if (out_ch !== '0) $display("FAIL reset_out_ch: got %h want 0", out_ch); else n_pass++;
    n_checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", out_ovf); else n_pass++;
    rst = 1'b0;
    set_in(1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
    cycle();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    repeat (3) cycle();
    n_checks++; if (got_q.size() != 0) $display("FAIL reset_no_output: got %0d results want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_add();
    int start;
    clear_logs();
    out_ready = 1'b1;
    set_in(1'b1, 2'd0, 1'b1, 8'hFF, 8'hFF);
    start = cyc;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    n_checks++; if (got_q.size() != 1) $display("FAIL add_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_checks++; if (got_cyc[0] - start != PS) $display("FAIL add_latency: got %0d want %0d", got_cyc[0] - start, PS); else n_pass++;
      n_checks++; if (got_q[0].sum !== 12'h1FE) $display("FAIL add_sum: got %h want 1fe", got_q[0].sum); else n_pass++;
      n_checks++; if (got_q[0].ch !== 1'b1) $display("FAIL add_ch: got %h want 1", got_q[0].ch); else n_pass++;
      n_checks++; if (got_q[0].ovf !== 1'b0) $display("FAIL add_ovf: got %b want 0", got_q[0].ovf); else n_pass++;
    end
  endtask

  task automatic test_load_acc();
    clear_logs();
    out_ready = 1'b1;
    set_in(1'b1, 2'd3, 1'b0, 8'h10, 8'hAA);
    cycle();
    set_in(1'b1, 2'd1, 1'b0, 8'h05, 8'h55);
    cycle();
    set_in(1'b1, 2'd1, 1'b1, 8'h00, 8'h33);  // read back ch1 accumulator
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    n_checks++; if (got_q.size() != 3) $display("FAIL ldacc_count: got %0d want 3", got_q.size()); else n_pass++;
    if (got_q.size() == 3) begin
      n_checks++; if (got_q[0].sum !== 12'h010) $display("FAIL ldacc_load: got %h want 010", got_q[0].sum); else n_pass++;
      n_checks++; if (got_q[1].sum !== 12'h015) $display("FAIL ldacc_acc: got %h want 015", got_q[1].sum); else n_pass++;
      n_checks++; if (got_cyc[1] - got_cyc[0] != 1) $display("FAIL ldacc_gap: got %0d want 1", got_cyc[1] - got_cyc[0]); else n_pass++;
      n_checks++; if (got_q[2].sum !== 12'h000 || got_q[2].ch !== 1'b1) $display("FAIL ldacc_ch1: got ch %h sum %h want ch 1 sum 000", got_q[2].ch, got_q[2].sum); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want_last;
    clear_logs();
    out_ready = 1'b1;
    want_last = SatEn ? 12'hFFF : 12'h0EF;
    set_in(1'b1, 2'd3, 1'b0, 8'hFF, 8'h00);
    cycle();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 2'd1, 1'b0, 8'hFF, 8'h00);
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    n_checks++; if (got_q.size() != 17) $display("FAIL wrap_count: got %0d want 17", got_q.size()); else n_pass++;
    if (got_q.size() == 17) begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (got_q[k].sum !== AW'(255 * (k + 1)) || got_q[k].ovf !== 1'b0)
          $display("FAIL wrap_step[%0d]: got %h/%b want %h/0", k, got_q[k].sum, got_q[k].ovf, AW'(255 * (k + 1)));
        else n_pass++;
      end
      n_checks++; if (got_q[16].sum !== want_last) $display("FAIL wrap_last_sum: got %h want %h", got_q[16].sum, want_last); else n_pass++;
      n_checks++; if (got_q[16].ovf !== 1'b1) $display("FAIL wrap_last_ovf: got %b want 1", got_q[16].ovf); else n_pass++;
    end
    // Leave ch0 in a known state for later tests.
    set_in(1'b1, 2'd2, 1'b0, 8'h00, 8'h00);
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_back_to_back_stall();
    logic [CHW-1:0] chs[6];
    logic [DW-1:0]  as[6];
    logic [DW-1:0]  bs[6];
    res_t           want;
    res_t           cur;
    int             k;
    int             stall_left;
    bit             armed;
    bit             acc;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      chs[i] = CHW'($urandom_range(0, NCH - 1));
      as[i]  = DW'($urandom);
      bs[i]  = DW'($urandom);
    end
    k          = 0;
    stall_left = 0;
    armed      = 1'b1;
    for (int c = 0; c < 60 && (k < 6 || got_q.size() < 6); c++) begin
      if (k < 6) set_in(1'b1, 2'd0, chs[k], as[k], bs[k]);
      else in_valid = 1'b0;
      if (got_q.size() == 2 && armed) begin
        stall_left = 3;
        armed      = 1'b0;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        want = {1'b1, chs[2], AW'(as[2]) + AW'(bs[2]), 1'b0};
        cur  = {out_valid, out_ch, out_sum, out_ovf};
        n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (cur !== want) $display("FAIL stall_hold: got %h want %h", cur, want); else n_pass++;
        stall_left--;
      end
      acc = in_valid && in_ready;
      cycle();
      if (acc) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    n_checks++; if (got_q.size() != 6) $display("FAIL stall_count: got %0d want 6", got_q.size()); else n_pass++;
    if (got_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        want = {1'b1, chs[i], AW'(as[i]) + AW'(bs[i]), 1'b0};
        n_checks++; if (got_q[i] !== want) $display("FAIL stall_order[%0d]: got %h want %h", i, got_q[i], want); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    out_ready = 1'b1;
    set_in(1'b1, 2'd3, 1'b1, 8'h40, 8'h00);
    cycle();
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    n_checks++; if (got_q.size() != 0) $display("FAIL rstmid_flush: got %0d results want 0", got_q.size()); else n_pass++;
    // Reset arriving while a result sits in the output stage.
    set_in(1'b1, 2'd0, 1'b0, 8'h01, 8'h02);
    cycle();
    in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else n_pass++;
    // A request presented during reset must not be taken.
    set_in(1'b1, 2'd3, 1'b1, 8'h77, 8'h00);
    cycle();
    rst = 1'b0;
    set_in(1'b1, 2'd1, 1'b1, 8'h01, 8'h00);
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    n_checks++; if (got_q.size() != 1) $display("FAIL rstmid_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() == 1) begin
      n_checks++;
      if (got_q[0].sum !== 12'h001 || got_q[0].ch !== 1'b1 || got_q[0].ovf !== 1'b0)
        $display("FAIL rstmid_acc: got %h want ch1 sum 001 ovf0", got_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    res_t held;
    res_t cur;
    bit   prev_stall;
    clear_logs();
    prev_stall = 1'b0;
    held       = '0;
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom), CHW'($urandom),
             ($urandom_range(0, 5) == 0) ? 8'hFF : DW'($urandom), DW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      cur = {out_valid, out_ch, out_sum, out_ovf};
      if (prev_stall) begin
        n_checks++; if (cur !== held) $display("FAIL rand_hold: got %h want %h", cur, held); else n_pass++;
      end
      prev_stall = out_valid && !out_ready;
      held       = cur;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (PS + 4) cycle();
    n_checks++; if (pend_q.size() != 0) $display("FAIL rand_lost: got %0d undelivered want 0", pend_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rand_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    set_in(1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_add();
    test_load_acc();
    test_wrap();
    test_back_to_back_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
